// File: rtl/dmem_ws.sv
// Word-organised data RAM behind a req/ready handshake with WAIT_STATES wait cycles,
// byte/half/word stores and sign/zero-extended loads. Optional macro: DMEM_ALIGN_CHK_EN.
module dmem_ws #(
  parameter int DEPTH       = 64,
  parameter int AW          = $clog2(DEPTH),
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [1:0]  bytes,
  input  logic        uns,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rd,
  output logic        err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [1:0]    bytes_q, bytes_d;
  logic          we_q, we_d;
  logic          uns_q, uns_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rd_q, rd_d;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   mem_rdata;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   load_val;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic          misalign;

  // Upper address bits only select aliases of the same word, so they are dropped.
  logic unused_a;
  assign unused_a = ^a[31:AW+2];

  assign idx       = addr_q[AW+1:2];
  assign mem_rdata = mem_q[idx];
  assign sel_byte  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign sel_half  = mem_rdata[{addr_q[1], 4'b0000} +: 16];

`ifdef DMEM_ALIGN_CHK_EN
  logic err_q, err_d;
  assign misalign = ((bytes_q == 2'd2) && addr_q[0]) ||
                    (((bytes_q == 2'd0) || (bytes_q == 2'd3)) && (addr_q[1:0] != 2'b00));
  assign err      = err_q;
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    load_val = mem_rdata;
    case (bytes_q)
      2'd1:    load_val = {{24{~uns_q & sel_byte[7]}}, sel_byte};
      2'd2:    load_val = {{16{~uns_q & sel_half[15]}}, sel_half};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    mem_wdata = mem_rdata;
    case (bytes_q)
      2'd1:    mem_wdata[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
      2'd2:    mem_wdata[{addr_q[1], 4'b0000} +: 16] = wd_q[15:0];
      default: mem_wdata = wd_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    bytes_d  = bytes_q;
    we_d     = we_q;
    uns_d    = uns_q;
    rd_d     = rd_q;
    rvalid_d = 1'b0;
    mem_we   = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = a[AW+1:0];
          wd_d    = wd;
          bytes_d = bytes;
          we_d    = we;
          uns_d   = uns;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d  = S_IDLE;
        rvalid_d = 1'b1;
        if (misalign) begin
          rd_d = '0;
`ifdef DMEM_ALIGN_CHK_EN
          err_d = 1'b1;
`endif
        end else if (we_q) begin
          mem_we = 1'b1;
        end else begin
          rd_d = load_val;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      bytes_q  <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rd_q     <= '0;
`ifdef DMEM_ALIGN_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      bytes_q  <= bytes_d;
      we_q     <= we_d;
      uns_q    <= uns_d;
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
`ifdef DMEM_ALIGN_CHK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Write enable comes from state_q, so an asynchronous reset suppresses a pending write.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= mem_wdata;
  end

  assign ready  = (state_q == S_IDLE);
  assign rvalid = rvalid_q;
  assign rd     = rd_q;

endmodule

// File: tb/tb_dmem_ws.sv
// Directed bench for dmem_ws with WAIT_STATES=2, DEPTH=64; expectations follow DMEM_ALIGN_CHK_EN.
module tb_dmem_ws;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [1:0]  bytes;
  logic        uns;
  logic        ready;
  logic        rvalid;
  logic [31:0] rd;
  logic        err;

  int errors = 0;
  int checks = 0;

  dmem_ws #(.DEPTH(64), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .a(a), .wd(wd),
    .bytes(bytes), .uns(uns), .ready(ready), .rvalid(rvalid), .rd(rd), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One handshake: drive at negedge, count edges to rvalid, check pulse shape.
  task automatic access(input string tag, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] sz, input logic u,
                        output logic [31:0] rd_o, output logic err_o);
    int lat;
    int rlow;
    @(negedge clk);
    req = 1'b1; we = w; a = addr; wd = data; bytes = sz; uns = u;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    rlow = 0;
    for (int i = 1; i <= 20; i++) begin
      if (!ready) rlow++;
      @(posedge clk); #1;
      lat = i;
      if (rvalid) break;
    end
    rd_o  = rd;
    err_o = err;
    check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
    check({tag, "_busy"}, 32'(rlow), 32'(WS + 1));
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'd0, rvalid, err}, 32'd0);
  endtask

  logic [31:0] r;
  logic        e;
  logic        seen;

  initial begin
    reset_n = 1'b0; req = 1'b0; we = 1'b0; a = '0; wd = '0; bytes = '0; uns = 1'b0;
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // word store/load with latency
    access("t1_st", 1'b1, 32'h10, 32'h8765_4321, 2'd0, 1'b0, r, e);
    check("t1_st_err", {31'd0, e}, 32'd0);
    check("t1_st_rdhold", r, 32'd0);
    access("t1_ld", 1'b0, 32'h10, 32'h0, 2'd0, 1'b0, r, e);
    check("t1_ld_rd", r, 32'h8765_4321);

    // byte merge and byte loads
    access("t2_w", 1'b1, 32'h10, 32'h1122_3344, 2'd0, 1'b0, r, e);
    access("t2_b", 1'b1, 32'h11, 32'hFFFF_FFAA, 2'd1, 1'b0, r, e);
    access("t2_lw", 1'b0, 32'h10, 32'h0, 2'd0, 1'b0, r, e);
    check("t2_word", r, 32'h1122_AA44);
    access("t2_lbs", 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, r, e);
    check("t2_lb_signed", r, 32'hFFFF_FFAA);
    access("t2_lbu", 1'b0, 32'h11, 32'h0, 2'd1, 1'b1, r, e);
    check("t2_lb_unsigned", r, 32'h0000_00AA);
    access("t2_lb3", 1'b0, 32'h13, 32'h0, 2'd1, 1'b0, r, e);
    check("t2_lb_lane3", r, 32'h0000_0011);

    // halfword merge and half loads
    access("t3_w", 1'b1, 32'h20, 32'hCAFE_BABE, 2'd0, 1'b0, r, e);
    check("t3_store_rdhold", r, 32'h0000_0011);
    access("t3_h", 1'b1, 32'h22, 32'h0000_8001, 2'd2, 1'b0, r, e);
    access("t3_lhs", 1'b0, 32'h22, 32'h0, 2'd2, 1'b0, r, e);
    check("t3_lh_signed", r, 32'hFFFF_8001);
    access("t3_lhu", 1'b0, 32'h22, 32'h0, 2'd2, 1'b1, r, e);
    check("t3_lh_unsigned", r, 32'h0000_8001);
    access("t3_lw", 1'b0, 32'h20, 32'h0, 2'd0, 1'b0, r, e);
    check("t3_word", r, 32'h8001_BABE);
    access("t3_lhl", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, r, e);
    check("t3_lh_low", r, 32'hFFFF_BABE);

    // address wrap modulo 256 bytes
    access("t4_st", 1'b1, 32'h100, 32'h5A5A_5A5A, 2'd0, 1'b0, r, e);
    access("t4_ld", 1'b0, 32'h000, 32'h0, 2'd0, 1'b0, r, e);
    check("t4_wrap", r, 32'h5A5A_5A5A);

    // reset during WAIT drops the store
    access("t5_init", 1'b1, 32'h04, 32'h0, 2'd0, 1'b0, r, e);
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h04; wd = 32'hDEAD_BEEF; bytes = 2'd0;
    @(posedge clk); #1;
    req = 1'b0;
    check("t5_busy", {31'd0, ready}, 32'd0);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("t5_rst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk); reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | rvalid;
    end
    check("t5_no_rvalid", {31'd0, seen}, 32'd0);
    check("t5_ready", {31'd0, ready}, 32'd1);
    access("t5_ld", 1'b0, 32'h04, 32'h0, 2'd0, 1'b0, r, e);
    check("t5_mem", r, 32'h0);

    // misaligned word store
    access("t6_pre", 1'b0, 32'h10, 32'h0, 2'd0, 1'b0, r, e);
    access("t6_st", 1'b1, 32'h06, 32'h1111_1111, 2'd0, 1'b0, r, e);
`ifdef DMEM_ALIGN_CHK_EN
    check("t6_err", {31'd0, e}, 32'd1);
    check("t6_rd", r, 32'h0);
    access("t6_ld", 1'b0, 32'h04, 32'h0, 2'd0, 1'b0, r, e);
    check("t6_mem", r, 32'h0);
`else
    check("t6_err", {31'd0, e}, 32'd0);
    check("t6_rd", r, 32'h1122_AA44);
    access("t6_ld", 1'b0, 32'h04, 32'h0, 2'd0, 1'b0, r, e);
    check("t6_mem", r, 32'h1111_1111);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ws.md
Name: dmem_ws

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-organised RAM behind a request/acknowledge handshake with a configurable number of wait states.
- Supports byte, halfword and word stores through byte-lane merging, and signed or unsigned sub-word loads.
- Sits between the multicycle/pipelined MIPS datapath (MEM stage) and on-chip data storage; the stall logic uses `ready` and `rvalid`.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, at least 2.
- AW, $clog2(DEPTH), word-index width; the index is a[AW+1:2].
- WAIT_STATES, 0, extra cycles between acceptance and access; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  1  request valid.
- we  input  1  1 = store, 0 = load.
- a  input  32  byte address.
- wd  input  32  store data, right-aligned (byte in wd[7:0], half in wd[15:0]).
- bytes  input  2  access size: 1 = byte, 2 = halfword, 0/3 = word.
- uns  input  1  load zero-extends when 1, sign-extends when 0.
- ready  output  1  block can accept a request this cycle.
- rvalid  output  1  one-cycle completion pulse, for loads and stores.
- rd  output  32  load result, registered.
- err  output  1  alignment fault flag, qualified by rvalid.

Behaviour:
- Interface: one clock `clk`; reset is asynchronous and active-low on `reset_n`.
- Reset values: state IDLE, wait counter 0, rvalid 0, rd 0, err 0. RAM contents are not reset.
- States:
  - IDLE: ready=1.
  - WAIT: ready=0, counter decrements each edge.
  - ACCESS: ready=0.
- Acceptance: req && ready at a rising edge.
  - Latches a, wd, bytes, we, uns.
  - Goes to WAIT with counter=WAIT_STATES-1 when WAIT_STATES>0, else to ACCESS.
- WAIT: moves to ACCESS on the edge where counter==0.
- ACCESS edge:
  - Performs the RAM operation.
  - Sets rvalid=1 for exactly one cycle.
  - Returns to IDLE.
- Latency: rvalid is high in the cycle following edge T0+WAIT_STATES+1, where T0 is the acceptance edge. Minimum request spacing is WAIT_STATES+2 cycles.
- req while ready=0 is ignored. The requester holds req until it is accepted.
- Store lanes:
  - bytes=1: RAM[idx][8*a[1:0]+:8] <= wd[7:0].
  - bytes=2: RAM[idx][16*a[1]+:16] <= wd[15:0].
  - Otherwise: whole word <= wd.
  - Other lanes are preserved.
  - rd holds its previous value on a store acknowledge.
- Load formatting:
  - bytes=1: selected byte (lane a[1:0]) extended to 32 bits.
  - bytes=2: halfword (lane a[1]) extended to 32 bits.
  - Otherwise: raw word.
  - Extension is by bit 7/15 when uns=0, by zeros when uns=1.
- Address wrap: bits above a[AW+1] are ignored, so the address wraps modulo DEPTH*4.
- Read-after-write: a load accepted after a store's rvalid returns the stored data. No bypass is needed because accesses are serialised.
- Reset mid-operation: the pending request is dropped, no RAM write occurs, and no rvalid is produced.

Optional Feature:
- Macro: DMEM_ALIGN_CHK_EN.
- Defined:
  - A halfword with a[0]=1, or a word with a[1:0]!=0, is misaligned.
  - A misaligned request still walks WAIT/ACCESS with normal latency.
  - In ACCESS: no RAM write, rd <= 0, err=1 together with rvalid.
  - err is cleared on the next edge, like rvalid.
- Undefined:
  - err is tied to 0.
  - Unused low address bits are ignored: halfwords use a[1] only, words ignore a[1:0].

Test Plan:
1. WAIT_STATES=2. Store word 0x8765_4321 to a=0x10, then load word from 0x10 → rvalid exactly 3 cycles after each acceptance edge; rd=0x8765_4321; ready low for 3 cycles per access.
2. Store byte wd=0xAA to a=0x11 over a word holding 0x1122_3344 → word reads 0x1122_AA44. Signed byte load at 0x11 → 0xFFFF_FFAA; unsigned byte load → 0x0000_00AA.
3. Store half 0x8001 to a=0x22, then signed and unsigned half loads at 0x22 → 0xFFFF_8001 and 0x0000_8001. Word at 0x20 has its low half unchanged.
4. DEPTH=64. Store 0x5A5A_5A5A to a=0x100, then load from a=0x000 → 0x5A5A_5A5A (wrap).
5. Assert reset_n low during WAIT of a store to 0x04 holding 0x0 → no rvalid, ready=1 after release, word at 0x04 still 0x0.
6. With DMEM_ALIGN_CHK_EN: word store at a=0x06 → rvalid with err=1, rd=0, memory unchanged. Without the macro: the same store writes the word at 0x04 and err=0.
